pong_ball: RTL and testbench

Ball motion engine for the pong display path. It sits upstream of the pixel/colour stage and beside the right paddle: once per video frame it advances the ball, bounces it off the walls and the right paddle, and detects misses. It publishes the ball's top-left coordinate, which the renderer compares against the x/y scan counters to draw the ball square. A serve state machine recentres the ball and delays play after reset-release/start and after every miss.

---
 rtl/pong_ball.sv | 184 ++++++++++++++++++
 tb/tb_pong_ball.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pong_ball.sv
// Ball motion engine: per-frame ball advance, wall/paddle bounce, miss detection, serve FSM.
// Optional feature macro BALL_SPEEDUP_EN: each paddle hit raises speed by one, up to MAX_SPEED.
module pong_ball #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int SPEED        = 2,
  parameter int MAX_SPEED    = 6,
  parameter int PADDLE_X_L   = 540,
  parameter int PADDLE_HALF  = 20,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] paddle_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       miss,
  output logic [3:0] miss_count,
  output logic       playing
);

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, MISS} state_t;

  localparam int CW = $clog2(SERVE_FRAMES + 1);
  localparam logic [10:0] BS   = 11'(BALL_SIZE);
  localparam logic [10:0] PH   = 11'(PADDLE_HALF);
  localparam logic [10:0] PXL  = 11'(PADDLE_X_L);
  localparam logic [10:0] XMAX = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] YMAX = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0]  CX   = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]  CY   = 10'((SCREEN_H - BALL_SIZE) / 2);
  // base speed can never start above the ceiling
  localparam logic [3:0]  S0   = 4'((SPEED > MAX_SPEED) ? MAX_SPEED : SPEED);
  localparam logic [3:0]  SMAX = 4'(MAX_SPEED);

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [3:0]      speed, spd_d;
  logic            dir_x, dx_d;
  logic            dir_y, dy_d;
  logic [9:0]      x_d, y_d;
  logic            miss_d;
  logic [3:0]      mc_d;

  logic [10:0]     s11, x11, y11, p11;
  logic            hit, out;
  logic [9:0]      x_mv, y_mv;
  logic            dx_mv, dy_mv;

  // dir_x: 1 = right, dir_y: 1 = down
  always_comb begin
    s11   = {7'd0, speed};
    x11   = {1'b0, ball_x};
    y11   = {1'b0, ball_y};
    p11   = {1'b0, paddle_y};
    hit   = dir_x && (x11 + BS <= PXL) && (x11 + BS + s11 >= PXL)
            && (y11 + BS + PH > p11) && (y11 < p11 + PH);
    out   = 1'b0;
    x_mv  = ball_x;
    dx_mv = dir_x;
    y_mv  = ball_y;
    dy_mv = dir_y;
    if (!dir_x) begin
      if (x11 < s11) begin
        x_mv  = 10'd0;
        dx_mv = 1'b1;
      end else begin
        x_mv = 10'(x11 - s11);
      end
    end else if (hit) begin
      x_mv  = 10'(PXL - BS);
      dx_mv = 1'b0;
    end else if (x11 + s11 > XMAX) begin
      out = 1'b1;
    end else begin
      x_mv = 10'(x11 + s11);
    end
    if (!dir_y) begin
      if (y11 < s11) begin
        y_mv  = 10'd0;
        dy_mv = 1'b1;
      end else begin
        y_mv = 10'(y11 - s11);
      end
    end else if (y11 + s11 > YMAX) begin
      y_mv  = 10'(YMAX);
      dy_mv = 1'b0;
    end else begin
      y_mv = 10'(y11 + s11);
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    spd_d   = speed;
    dx_d    = dir_x;
    dy_d    = dir_y;
    x_d     = ball_x;
    y_d     = ball_y;
    miss_d  = 1'b0;
    mc_d    = miss_count;
    unique case (state)
      IDLE: begin
        if (frame_tick && start) begin
          state_d = SERVE;
          cnt_d   = CW'(SERVE_FRAMES);
          spd_d   = S0;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (cnt == CW'(1)) begin
            state_d = PLAY;
            dx_d    = 1'b0;
          end else begin
            cnt_d = cnt - CW'(1);
          end
        end
      end
      PLAY: begin
        if (frame_tick) begin
          if (out) begin
            state_d = MISS;
            miss_d  = 1'b1;
            mc_d    = miss_count + 4'd1;
          end else begin
            x_d  = x_mv;
            dx_d = dx_mv;
            y_d  = y_mv;
            dy_d = dy_mv;
`ifdef BALL_SPEEDUP_EN
            if (hit && speed < SMAX)
              spd_d = speed + 4'd1;
`else
            if (speed > SMAX)
              spd_d = SMAX;
`endif
          end
        end
      end
      MISS: begin
        if (frame_tick) begin
          state_d = SERVE;
          cnt_d   = CW'(SERVE_FRAMES);
          spd_d   = S0;
          x_d     = CX;
          y_d     = CY;
          dy_d    = ~dir_y;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      speed      <= S0;
      dir_x      <= 1'b0;
      dir_y      <= 1'b1;
      ball_x     <= CX;
      ball_y     <= CY;
      miss       <= 1'b0;
      miss_count <= 4'd0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      speed      <= spd_d;
      dir_x      <= dx_d;
      dir_y      <= dy_d;
      ball_x     <= x_d;
      ball_y     <= y_d;
      miss       <= miss_d;
      miss_count <= mc_d;
    end
  end

  assign playing = (state == PLAY);

endmodule

// File: tb/tb_pong_ball.sv
// Directed bench for pong_ball: serve timing, wall bounces, paddle hit, miss, wrap, async reset.
module tb_pong_ball;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic [9:0] paddle_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       miss;
  logic [3:0] miss_count;
  logic       playing;

  int checks = 0;
  int errors = 0;
  int k = 0;

  pong_ball dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start      (start),
    .paddle_y   (paddle_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .miss       (miss),
    .miss_count (miss_count),
    .playing    (playing)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (k < target) begin
      tick();
      k++;
    end
  endtask

  task automatic serve_to_play();
    start = 1'b1;
    tick();
    check("serve_entry_playing", 32'(playing), 0);
    start = 1'b0;
    repeat (59) tick();
    check("serve_hold_playing", 32'(playing), 0);
    tick();
    check("play_entry_playing", 32'(playing), 1);
    check("play_entry_x", 32'(ball_x), 316);
    check("play_entry_y", 32'(ball_y), 236);
    k = 0;
  endtask

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    start      = 1'b0;
    paddle_y   = 10'd140;
    repeat (3) @(negedge clk);
    check("rst_x", 32'(ball_x), 316);
    check("rst_y", 32'(ball_y), 236);
    check("rst_miss", 32'(miss), 0);
    check("rst_count", 32'(miss_count), 0);
    check("rst_playing", 32'(playing), 0);
    reset = 1'b0;

    tick();
    check("idle_nostart", 32'(playing), 0);
    check("idle_x", 32'(ball_x), 316);
    serve_to_play();

    run_to(1);
    check("k1_x", 32'(ball_x), 314);
    check("k1_y", 32'(ball_y), 238);
    run_to(118);
    check("bot_y118", 32'(ball_y), 472);
    run_to(119);
    check("bot_y119", 32'(ball_y), 472);
    check("x119", 32'(ball_x), 78);
    run_to(120);
    check("bot_y120", 32'(ball_y), 470);
    run_to(158);
    check("left_x158", 32'(ball_x), 0);
    run_to(159);
    check("left_x159", 32'(ball_x), 0);
    run_to(160);
    check("left_x160", 32'(ball_x), 2);
    run_to(355);
    check("top_y355", 32'(ball_y), 0);
    run_to(356);
    check("top_y356", 32'(ball_y), 0);
    run_to(357);
    check("top_y357", 32'(ball_y), 2);
    check("x357", 32'(ball_x), 396);
    run_to(424);
    check("pre_hit_x", 32'(ball_x), 530);
    check("pre_hit_y", 32'(ball_y), 136);
    run_to(425);
    check("hit_x", 32'(ball_x), 532);
    check("hit_y", 32'(ball_y), 138);
    run_to(426);
`ifdef BALL_SPEEDUP_EN
    check("post_hit_x", 32'(ball_x), 529);
    check("post_hit_y", 32'(ball_y), 141);
`else
    check("post_hit_x", 32'(ball_x), 530);
    check("post_hit_y", 32'(ball_y), 140);
`endif

    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_x", 32'(ball_x), 316);
    check("async_rst_y", 32'(ball_y), 236);
    check("async_rst_playing", 32'(playing), 0);
    check("async_rst_count", 32'(miss_count), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick();
    check("idle_after_rst", 32'(playing), 0);
    check("idle_after_rst_x", 32'(ball_x), 316);

    paddle_y = 10'd1023;
    serve_to_play();
    run_to(475);
    check("edge_x", 32'(ball_x), 632);
    check("edge_y", 32'(ball_y), 238);
    run_to(476);
    check("miss_pulse", 32'(miss), 1);
    check("miss_count1", 32'(miss_count), 1);
    check("miss_playing", 32'(playing), 0);
    check("miss_frozen_x", 32'(ball_x), 632);
    check("miss_frozen_y", 32'(ball_y), 238);
    @(negedge clk);
    check("miss_one_clk", 32'(miss), 0);
    tick();
    check("reserve_x", 32'(ball_x), 316);
    check("reserve_y", 32'(ball_y), 236);
    check("reserve_playing", 32'(playing), 0);
    repeat (60) tick();
    check("replay_playing", 32'(playing), 1);
    tick();
    check("replay_x", 32'(ball_x), 314);
    check("replay_y_up", 32'(ball_y), 234);

    for (int i = 0; i < 15; i++) begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 700 && !seen; n++) begin
        tick();
        if (miss === 1'b1) seen = 1'b1;
      end
      check("wrap_miss_seen", 32'(seen), 1);
      check("wrap_count", 32'(miss_count), 32'((i + 2) % 16));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
